// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and requester encoding for the writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    ReqAlu = 1'b0,
    ReqMem = 1'b1
  } req_id_e;

  // The requester that should win the next tie after `id` was granted.
  function automatic req_id_e other_req(req_id_e id);
    return (id == ReqAlu) ? ReqMem : ReqAlu;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set by issue, cleared by writeback.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next-state: clear first so a same-cycle set (newer producer) wins; r0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] destReg,
  output logic [DATA_W-1:0]     writeData,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  grant_mem
);

  // Requester favoured when both are valid.
  req_id_e rr_fav_q, rr_fav_d;

  logic                  alu_fire, mem_fire, xfer;
  logic [REG_ADDR_W-1:0] xfer_dest;
  logic [DATA_W-1:0]     xfer_data;

  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     data_q;
  logic                  grant_mem_q;

  // Grant: lone requester wins at once; ties resolved by pointer or fixed MEM priority.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        if ((RR_EN != 0) && (rr_fav_q == ReqAlu)) alu_ready = 1'b1;
        else                                      mem_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign alu_fire  = alu_valid & alu_ready;
  assign mem_fire  = mem_valid & mem_ready;
  assign xfer      = alu_fire | mem_fire;
  assign xfer_dest = mem_fire ? mem_dest : alu_dest;
  assign xfer_data = mem_fire ? mem_data : alu_data;

  // Pointer moves to the loser of every transfer, contended or not.
  always_comb begin
    rr_fav_d = rr_fav_q;
    if (xfer) rr_fav_d = other_req(mem_fire ? ReqMem : ReqAlu);
  end

  // Write-port register: one-cycle delayed write; r0 transfers are swallowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_fav_q    <= ReqMem;
      reg_write_q <= 1'b0;
      dest_q      <= '0;
      data_q      <= '0;
      grant_mem_q <= 1'b0;
    end else begin
      rr_fav_q    <= rr_fav_d;
      reg_write_q <= xfer && (xfer_dest != '0);
      if (xfer) begin
        dest_q      <= xfer_dest;
        data_q      <= xfer_data;
        grant_mem_q <= mem_fire;
      end
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue_valid && (issue_dest != '0)),
    .set_idx  (issue_dest),
    .clr_en   (xfer),
    .clr_idx  (xfer_dest),
    .busy_vec (busy_vec)
  );

  assign regWrite  = reg_write_q;
  assign destReg   = dest_q;
  assign writeData = data_q;
  assign grant_mem = grant_mem_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_dest, mem_dest, issue_dest;
  logic [31:0] alu_data, mem_data;

  logic        rr_alu_ready, rr_mem_ready, rr_we, rr_gm;
  logic [4:0]  rr_dest;
  logic [31:0] rr_data, rr_busy;
  logic        fp_alu_ready, fp_mem_ready, fp_we, fp_gm;
  logic [4:0]  fp_dest;
  logic [31:0] fp_data, fp_busy;

  regfile_wb_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(rr_alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(rr_mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .regWrite(rr_we), .destReg(rr_dest), .writeData(rr_data),
    .busy_vec(rr_busy), .grant_mem(rr_gm)
  );

  regfile_wb_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(fp_alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(fp_mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .regWrite(fp_we), .destReg(fp_dest), .writeData(fp_data),
    .busy_vec(fp_busy), .grant_mem(fp_gm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file fed by the round-robin instance's write port.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rr_we && (rr_dest != 5'd0)) begin
      rf[rr_dest] <= rr_data;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model, index 0 = round-robin, 1 = fixed priority.
  // grant codes: 0 none, 1 ALU, 2 MEM.
  bit        m_last_alu [2] = '{1'b1, 1'b1};
  bit        m_we       [2] = '{1'b0, 1'b0};
  bit [4:0]  m_dest     [2] = '{5'd0, 5'd0};
  bit [31:0] m_data     [2] = '{32'd0, 32'd0};
  bit        m_gm       [2] = '{1'b0, 1'b0};
  bit [31:0] m_busy     [2] = '{32'd0, 32'd0};
  int        g          [2];
  bit        m_was_rst;
  bit [3:0]  s_rdy;

  function automatic int pick(input int k);
    if (reset) return 0;
    if (alu_valid && mem_valid) begin
      if (k == 0 && !m_last_alu[0]) return 1;
      return 2;
    end
    if (mem_valid) return 2;
    if (alu_valid) return 1;
    return 0;
  endfunction

  task automatic model_update(input int k);
    bit [4:0] d;
    if (reset) begin
      m_we[k] = 0; m_dest[k] = 0; m_data[k] = 0; m_gm[k] = 0; m_busy[k] = 0;
      m_last_alu[k] = 1;
    end else begin
      if (g[k] == 0) begin
        m_we[k] = 0;
      end else begin
        d = (g[k] == 2) ? mem_dest : alu_dest;
        m_we[k]       = (d != 0);
        m_dest[k]     = d;
        m_data[k]     = (g[k] == 2) ? mem_data : alu_data;
        m_gm[k]       = (g[k] == 2);
        m_last_alu[k] = (g[k] == 1);
        m_busy[k][d]  = 1'b0;
      end
      if (issue_valid && issue_dest != 0) m_busy[k][issue_dest] = 1'b1;
    end
  endtask

  task automatic check_regs(input int k, input logic we, input logic gmv, input logic [4:0] d,
                            input logic [31:0] wd, input logic [31:0] bv);
    string p;
    p = (k == 0) ? "rr" : "fp";
    check({p, " regWrite"}, 32'(we), 32'(m_we[k]));
    check({p, " grant_mem"}, 32'(gmv), 32'(m_gm[k]));
    check({p, " busy_vec"}, bv, m_busy[k]);
    if (m_we[k] || m_was_rst) begin
      check({p, " destReg"}, 32'(d), 32'(m_dest[k]));
      check({p, " writeData"}, wd, m_data[k]);
    end
  endtask

  // One clock: readies checked mid-cycle, registered outputs just after the edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) g[k] = pick(k);
    s_rdy = {rr_alu_ready, rr_mem_ready, fp_alu_ready, fp_mem_ready};
    check("rr alu_ready", 32'(rr_alu_ready), 32'(g[0] == 1));
    check("rr mem_ready", 32'(rr_mem_ready), 32'(g[0] == 2));
    check("fp alu_ready", 32'(fp_alu_ready), 32'(g[1] == 1));
    check("fp mem_ready", 32'(fp_mem_ready), 32'(g[1] == 2));
    @(posedge clk);
    #1;
    m_was_rst = reset;
    for (int k = 0; k < 2; k++) model_update(k);
    check_regs(0, rr_we, rr_gm, rr_dest, rr_data, rr_busy);
    check_regs(1, fp_we, fp_gm, fp_dest, fp_data, fp_busy);
  endtask

  typedef struct {
    bit        rst;
    bit        av;
    bit [4:0]  ad;
    bit [31:0] adata;
    bit        mv;
    bit [4:0]  md;
    bit [31:0] mdata;
    bit        iv;
    bit [4:0]  id;
    bit [3:0]  rdy;   // {rr alu, rr mem, fp alu, fp mem}
    bit        we;    // round-robin instance, after the edge
    bit        gm;
    bit [31:0] busy;
    bit        chk;   // compare destReg/writeData
    bit [4:0]  dest;
    bit [31:0] data;
  } vec_t;

  localparam bit [31:0] DA = 32'hA1A1_0001;
  localparam bit [31:0] DM = 32'hB2B2_0002;
  localparam bit [31:0] DC = 32'hCAFE_0008;
  localparam bit [31:0] Z  = 32'h0;

  vec_t tbl [22];

  bit       a_pend, m_pend;

  initial begin
    reset = 1'b1;
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_dest = 0; mem_dest = 0; issue_dest = 0; alu_data = 0; mem_data = 0;

    //          rst   av    ad     adata         mv    md     mdata  iv    id     rdy      we    gm    busy          chk   dest   data
    tbl[0]  = '{1'b1, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, Z,            1'b1, 5'd0,  Z};
    tbl[1]  = '{1'b1, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, Z,            1'b1, 5'd0,  Z};
    tbl[2]  = '{1'b0, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b0101, 1'b1, 1'b1, Z,            1'b1, 5'd2,  DM};
    tbl[3]  = '{1'b0, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b1001, 1'b1, 1'b0, Z,            1'b1, 5'd1,  DA};
    tbl[4]  = '{1'b0, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b0101, 1'b1, 1'b1, Z,            1'b1, 5'd2,  DM};
    tbl[5]  = '{1'b0, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b1001, 1'b1, 1'b0, Z,            1'b1, 5'd1,  DA};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, Z,            1'b1, 5'd1,  DA};
    tbl[7]  = '{1'b0, 1'b1, 5'd5,  32'h1234,     1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b1010, 1'b1, 1'b0, Z,            1'b1, 5'd5,  32'h1234};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, Z,            1'b1, 5'd5,  32'h1234};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b1, 5'd8,  4'b0000, 1'b0, 1'b0, 32'h100,      1'b1, 5'd5,  32'h1234};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, 32'h100,      1'b1, 5'd5,  32'h1234};
    tbl[11] = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, 32'h100,      1'b1, 5'd5,  32'h1234};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  Z,            1'b1, 5'd8,  DC,    1'b0, 5'd0,  4'b0101, 1'b1, 1'b1, Z,            1'b1, 5'd8,  DC};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b0000, 1'b0, 1'b1, Z,            1'b1, 5'd8,  DC};
    tbl[14] = '{1'b0, 1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  Z,     1'b1, 5'd3,  4'b1010, 1'b1, 1'b0, 32'h8,        1'b1, 5'd3,  32'h33};
    tbl[15] = '{1'b0, 1'b1, 5'd3,  32'h333,      1'b0, 5'd0,  Z,     1'b1, 5'd0,  4'b1010, 1'b1, 1'b0, Z,            1'b1, 5'd3,  32'h333};
    tbl[16] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b1010, 1'b0, 1'b0, Z,            1'b0, 5'd0,  Z};
    tbl[17] = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, Z,            1'b0, 5'd0,  Z};
    tbl[18] = '{1'b0, 1'b0, 5'd0,  Z,            1'b1, 5'd9,  32'h99, 1'b0, 5'd0, 4'b0101, 1'b1, 1'b1, Z,            1'b1, 5'd9,  32'h99};
    tbl[19] = '{1'b1, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, Z,            1'b1, 5'd0,  Z};
    tbl[20] = '{1'b0, 1'b1, 5'd1,  DA,           1'b1, 5'd2,  DM,    1'b0, 5'd0,  4'b0101, 1'b1, 1'b1, Z,            1'b1, 5'd2,  DM};
    tbl[21] = '{1'b0, 1'b0, 5'd0,  Z,            1'b0, 5'd0,  Z,     1'b0, 5'd0,  4'b0000, 1'b0, 1'b1, Z,            1'b1, 5'd2,  DM};

    for (int i = 0; i < 22; i++) begin
      reset       = tbl[i].rst;
      alu_valid   = tbl[i].av;   alu_dest = tbl[i].ad; alu_data = tbl[i].adata;
      mem_valid   = tbl[i].mv;   mem_dest = tbl[i].md; mem_data = tbl[i].mdata;
      issue_valid = tbl[i].iv;   issue_dest = tbl[i].id;
      step();
      check($sformatf("row%0d readies", i), 32'(s_rdy), 32'(tbl[i].rdy));
      check($sformatf("row%0d regWrite", i), 32'(rr_we), 32'(tbl[i].we));
      check($sformatf("row%0d grant_mem", i), 32'(rr_gm), 32'(tbl[i].gm));
      check($sformatf("row%0d busy_vec", i), rr_busy, tbl[i].busy);
      if (tbl[i].chk) begin
        check($sformatf("row%0d destReg", i), 32'(rr_dest), 32'(tbl[i].dest));
        check($sformatf("row%0d writeData", i), rr_data, tbl[i].data);
      end
      if (i == 17) begin
        check("rf r8", rf[8], DC);
        check("rf r5", rf[5], 32'h1234);
        check("rf r3", rf[3], 32'h333);
        check("rf r0", rf[0], Z);
      end
    end

    // Randomised traffic; requests are held until the round-robin instance grants them.
    a_pend = 0;
    m_pend = 0;
    for (int n = 0; n < 600; n++) begin
      if (!a_pend && $urandom_range(0, 1) == 1) begin
        a_pend   = 1;
        alu_dest = 5'($urandom_range(0, 31));
        alu_data = $urandom();
      end
      if (!m_pend && $urandom_range(0, 1) == 1) begin
        m_pend   = 1;
        mem_dest = 5'($urandom_range(0, 31));
        mem_data = $urandom();
      end
      alu_valid   = a_pend;
      mem_valid   = m_pend;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_dest  = 5'($urandom_range(0, 31));
      reset       = ($urandom_range(0, 63) == 0);
      step();
      if (g[0] == 1) a_pend = 0;
      if (g[0] == 2) m_pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with MEM over ALU.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock shared with the register file.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 alu_valid / alu_ready  input / output  1 / 1  ALU writeback handshake.
REQ-006 alu_dest / alu_data  input  5 / 32  ALU destination register and result.
REQ-007 mem_valid / mem_ready  input / output  1 / 1  load writeback handshake.
REQ-008 mem_dest / mem_data  input  5 / 32  load destination register and data.
REQ-009 issue_valid / issue_dest  input  1 / 5  an instruction that will write issue_dest has issued.
REQ-010 regWrite / destReg / writeData  output  1 / 5 / 32  drives the register file write port.
REQ-011 busy_vec  output  32  bit i = register i has a pending writer.
REQ-012 grant_mem  output  1  registered; 1 = the last accepted write came from MEM.

Function
REQ-013 A transfer SHALL occur on a cycle where valid and ready are both 1; a requester holds valid, dest and data stable until that cycle.
REQ-014 ready SHALL be combinational from valid and arbitration state: at most one of alu_ready/mem_ready is 1 per cycle, and neither is 1 unless its valid is 1.
REQ-015 Single requester valid: that requester SHALL be granted in the same cycle; there are no idle bubbles.
REQ-016 Both valid with RR_EN=1: grant SHALL go to the requester not granted at the most recent transfer; after reset the pointer favours MEM.
REQ-017 Both valid with RR_EN=0: MEM SHALL always win.
REQ-018 Latency: a transfer in cycle N SHALL present regWrite=1 with the registered dest and data during cycle N+1, so the register file writes on the edge ending N+1.
REQ-019 A transfer with dest=0 SHALL be accepted (ready=1) but SHALL leave regWrite 0 in cycle N+1.
REQ-020 regWrite SHALL be 0 in every cycle that follows a cycle with no transfer; destReg and writeData then hold their previous values.
REQ-021 issue_valid with issue_dest!=0 SHALL set busy_vec[issue_dest] at the clock edge.
REQ-022 A transfer SHALL clear busy_vec[dest] at the edge ending the transfer cycle.
REQ-023 Set and clear of the same bit in the same cycle: set SHALL win, because the newer producer is pending.
REQ-024 busy_vec[0] SHALL be constant 0.
REQ-025 A transfer to a register that is not busy SHALL still be written; busy_vec is unaffected.

Reset
REQ-026 Under reset, all outputs SHALL be 0 at the next edge: regWrite, destReg, writeData, busy_vec, grant_mem.
REQ-027 During reset, alu_ready and mem_ready SHALL be 0.
REQ-028 Reset SHALL return the round-robin pointer to MEM-favoured.
REQ-029 Reset asserted mid-operation SHALL discard an accepted-but-unwritten transfer: regWrite is 0 in the following cycle.

Structure
REQ-030 A shared package SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and the requester ID encoding (ALU=0, MEM=1).
REQ-031 The busy scoreboard SHALL be a sub-module, regfile_scoreboard, with set/clear ports.
REQ-032 Arbitration and the write-port register SHALL live in the top module.

Verification
REQ-033 Reset with both valids high -> readies 0; one cycle after reset release mem_ready=1 and alu_ready=0; regWrite=0 throughout reset.
REQ-034 ALU alone, dest=5, data=0x1234 in cycle N -> alu_ready=1 in N; regWrite=1, destReg=5, writeData=0x1234 in N+1; regWrite=0 in N+2.
REQ-035 Both valid for 4 cycles, RR_EN=1 -> grants M,A,M,A and grant_mem=1,0,1,0; with RR_EN=0 -> 4×M and alu_ready=0.
REQ-036 issue_dest=8, then MEM write to 8 three cycles later -> busy_vec[8]=1 for 3 cycles, then 0; register file read of 8 afterwards returns the written data.
REQ-037 issue_dest=3 and an ALU transfer to 3 in the same cycle -> busy_vec[3]=1 after the edge; issue_dest=0 -> busy_vec=0.
REQ-038 ALU write to dest=0 with data=0xFFFFFFFF -> accepted; regWrite stays 0; register 0 reads 0.
